// File: rtl/left_shift_of_8_by_3_if.sv
// Operand/result bundle for the fixed 8-bit left-shift-by-3 block.
interface left_shift_of_8_by_3_if;
  localparam int unsigned N = 8;

  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] res_concat;
  logic [N-1:0] res_always;
  logic [N-1:0] res_generate;
  logic         out_valid;
  logic [N-1:0] res_q;
  logic         mismatch;

  modport master (
    output in_valid, a,
    input  res_concat, res_always, res_generate, out_valid, res_q, mismatch
  );

  modport slave (
    input  in_valid, a,
    output res_concat, res_always, res_generate, out_valid, res_q, mismatch
  );
endinterface

// File: rtl/left_shift_of_8_by_3.sv
// Logical left shift of an 8-bit operand by 3, built three independent ways,
// with a registered result and a sticky flag that fires if the builds ever disagree.
module left_shift_of_8_by_3 (
  input logic                  clk,
  input logic                  rst,
  left_shift_of_8_by_3_if.slave bus
);
  localparam int unsigned N = 8;
  localparam int unsigned S = 3;

  logic [N-1:0] shift_concat;
  logic [N-1:0] shift_always;
  logic [N-1:0] shift_generate;
  logic [N-1:0] res_q_q;
  logic         out_valid_q;
  logic         mismatch_q;

  assign shift_concat = {bus.a[N-S-1:0], 3'b000};

  always_comb begin
    shift_always = '0;
    for (int i = S; i < N; i++) begin
      shift_always[i] = bus.a[i-S];
    end
  end

  // Low S bits are tied off; upper bits take a[i-S].
  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i < S) begin : g_zero
      assign shift_generate[i] = 1'b0;
    end else begin : g_copy
      assign shift_generate[i] = bus.a[i-S];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q_q     <= '0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        res_q_q <= shift_concat;
      end
      if ((shift_concat != shift_always) || (shift_concat != shift_generate)) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign bus.res_concat   = shift_concat;
  assign bus.res_always   = shift_always;
  assign bus.res_generate = shift_generate;
  assign bus.res_q        = res_q_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.mismatch     = mismatch_q;
endmodule

// File: tb/tb_left_shift_of_8_by_3.sv
// Self-checking bench for left_shift_of_8_by_3: directed corners, full sweep,
// hold, mid-stream reset and randomized traffic against an arithmetic model.
module tb_left_shift_of_8_by_3;
  logic clk;
  logic rst;

  left_shift_of_8_by_3_if bus ();

  left_shift_of_8_by_3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q;
  logic       exp_ov;
  logic       exp_mm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected shift from plain arithmetic: multiply by 8, keep the low byte.
  function automatic logic [7:0] ref_shift(input logic [7:0] v);
    int t;
    t = int'(v) * 8;
    return 8'(t % 256);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, check combinational outputs, clock once, check registered outputs.
  task automatic cycle(input logic v, input logic [7:0] val);
    bus.in_valid = v;
    bus.a        = val;
    #1;
    check("res_concat",   bus.res_concat,   ref_shift(val));
    check("res_always",   bus.res_always,   ref_shift(val));
    check("res_generate", bus.res_generate, ref_shift(val));
    @(posedge clk);
    if (!rst) begin
      exp_q  = 8'h00;
      exp_ov = 1'b0;
      exp_mm = 1'b0;
    end else begin
      exp_ov = v;
      if (v) exp_q = ref_shift(val);
    end
    #1;
    check("res_q",     bus.res_q,              exp_q);
    check("out_valid", 8'(bus.out_valid),      8'(exp_ov));
    check("mismatch",  8'(bus.mismatch),       8'(exp_mm));
  endtask

  initial begin
    logic [7:0] corners [5];
    corners[0] = 8'b10110111;
    corners[1] = 8'hFF;
    corners[2] = 8'h01;
    corners[3] = 8'hE0;
    corners[4] = 8'h00;

    exp_q  = 8'h00;
    exp_ov = 1'b0;
    exp_mm = 1'b0;
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 8'hAA;

    // Reset with in_valid high: nothing captured.
    repeat (2) cycle(1'b1, 8'hAA);
    rst = 1'b1;

    // Directed corners, including the worked example.
    foreach (corners[i]) cycle(1'b1, corners[i]);
    bus.in_valid = 1'b0;
    #1;

    // Exhaustive sweep with in_valid every cycle.
    for (int v = 0; v < 256; v++) cycle(1'b1, 8'(v));

    // Capture then hold.
    cycle(1'b1, 8'h1F);
    check("hold_capture", bus.res_q, 8'hF8);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'h03);
      check("hold_value", bus.res_q, 8'hF8);
      check("hold_concat", bus.res_concat, 8'h18);
    end

    // Mid-stream reset overrides in_valid.
    cycle(1'b1, 8'h33);
    rst = 1'b0;
    cycle(1'b1, 8'h55);
    check("rst_res_q", bus.res_q, 8'h00);
    check("rst_concat", bus.res_concat, 8'hA8);
    rst = 1'b1;
    cycle(1'b1, 8'h55);
    check("post_rst_res_q", bus.res_q, 8'hA8);

    // Randomized traffic.
    for (int k = 0; k < 20; k++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
